// File: rtl/ff_loader.sv
// ff_loader: stream-to-memory-map sequencer for the feed-forward network.
//
// This block is the only master on the network's register port. It takes one
// frame of words from the input stream and writes it into the weight and input
// registers. It then waits for the network to signal completion, reads each
// output neuron back and emits it on the result stream.
//
// Ports
//   clk_i, reset_i           clock; synchronous active-high reset
//   cfg_start_i              one-cycle frame request, honoured only in IDLE
//   cfg_load_w_i             sampled with cfg_start_i; frame carries NW weights first
//   s_valid_i/s_ready_o/s_data_i      frame word stream in
//   m_valid_o/m_ready_i/m_data_o/m_last_o  result stream out (LENGHT_O words)
//   net_write_o, net_read_o  network write / read strobes
//   net_address_o            network register address
//   net_in_d_o               network write data
//   net_out_d_i              network read data, valid the cycle after net_read_o
//   net_ready_i              network can accept a write
//   net_down_i               network computation complete (level)
//   busy_o                   high in every state except IDLE
//   err_o                    sticky completion-timeout flag, cleared by a new start
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for cfg_start_i
// LOAD_W    | forwarding stream words to weight registers
// LOAD_I    | forwarding stream words to input registers
// GUARD     | one cycle that ignores a completion left over from last frame
// WAIT_DONE | waiting for net_down_i, with timeout
// RD_REQ    | read strobe for output word cnt
// RD_DATA   | capture read data into the result register
// EMIT      | present result word until accepted

module ff_loader #(
    parameter  int WIDTH      = 32,
    parameter  int LENGHT_I   = 8,
    parameter  int LENGHT_MID = 4,
    parameter  int LENGHT_O   = 2,
    parameter  int TIMEOUT    = 1024,
    localparam int NW         = LENGHT_I * LENGHT_MID + LENGHT_MID * LENGHT_O,
    localparam int W_BASE     = 0,
    localparam int I_BASE     = NW + 1,
    localparam int O_BASE     = NW + LENGHT_I + 2,
    localparam int WIDTH_ADDR = $clog2(NW + LENGHT_I + LENGHT_O + 3)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cfg_start_i,
    input  logic                  cfg_load_w_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [WIDTH-1:0]      s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [WIDTH-1:0]      m_data_o,
    output logic                  m_last_o,
    output logic                  net_write_o,
    output logic                  net_read_o,
    output logic [WIDTH_ADDR-1:0] net_address_o,
    output logic [WIDTH-1:0]      net_in_d_o,
    input  logic [WIDTH-1:0]      net_out_d_i,
    input  logic                  net_ready_i,
    input  logic                  net_down_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int CMAX = (NW > LENGHT_I) ? ((NW > LENGHT_O) ? NW : LENGHT_O)
                                          : ((LENGHT_I > LENGHT_O) ? LENGHT_I : LENGHT_O);
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_I, GUARD, WAIT_DONE, RD_REQ, RD_DATA, EMIT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  m_data_q, m_data_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tmr_q    <= '0;
            err_q    <= 1'b0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            err_q    <= err_d;
            m_data_q <= m_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        err_d         = err_q;
        m_data_d      = m_data_q;
        s_ready_o     = 1'b0;
        m_valid_o     = 1'b0;
        m_last_o      = 1'b0;
        net_write_o   = 1'b0;
        net_read_o    = 1'b0;
        net_address_o = '0;
        net_in_d_o    = '0;

        case (state_q)
            IDLE: begin
                if (cfg_start_i) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = cfg_load_w_i ? LOAD_W : LOAD_I;
                end
            end
            LOAD_W: begin
                s_ready_o = net_ready_i;
                if (s_valid_i && net_ready_i) begin
                    net_write_o   = 1'b1;
                    net_address_o = WIDTH_ADDR'(W_BASE) + WIDTH_ADDR'(cnt_q);
                    net_in_d_o    = s_data_i;
                    if (cnt_q == CW'(NW - 1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_I;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_I: begin
                s_ready_o = net_ready_i;
                if (s_valid_i && net_ready_i) begin
                    net_write_o   = 1'b1;
                    net_address_o = WIDTH_ADDR'(I_BASE) + WIDTH_ADDR'(cnt_q);
                    net_in_d_o    = s_data_i;
                    if (cnt_q == CW'(LENGHT_I - 1)) begin
                        cnt_d   = '0;
                        state_d = GUARD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            GUARD: begin
                tmr_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (net_down_i) begin
                    cnt_d   = '0;
                    state_d = RD_REQ;
                end else if (TIMEOUT != 0 && tmr_q == TMAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RD_REQ: begin
                net_read_o    = 1'b1;
                net_address_o = WIDTH_ADDR'(O_BASE) + WIDTH_ADDR'(cnt_q);
                state_d       = RD_DATA;
            end
            RD_DATA: begin
                m_data_d = net_out_d_i;
                state_d  = EMIT;
            end
            EMIT: begin
                m_valid_o = 1'b1;
                m_last_o  = (cnt_q == CW'(LENGHT_O - 1));
                if (m_ready_i) begin
                    if (m_last_o) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // While reset is held nothing may be handed to the network or the
        // result consumer, even though the state register has not cleared yet.
        if (reset_i) begin
            s_ready_o     = 1'b0;
            m_valid_o     = 1'b0;
            m_last_o      = 1'b0;
            net_write_o   = 1'b0;
            net_read_o    = 1'b0;
            net_address_o = '0;
            net_in_d_o    = '0;
        end
    end

    assign m_data_o = m_data_q;
    assign busy_o   = (state_q != IDLE);
    assign err_o    = err_q;

endmodule

// File: tb/tb_ff_loader.sv
module tb_ff_loader;

    logic        clk = 1'b0;
    logic        reset, cfg_start, cfg_load_w;
    logic        s_valid, s_ready, m_valid, m_ready, m_last;
    logic [31:0] s_data, m_data, net_in_d;
    logic [31:0] net_out_d = 32'hDEADDEAD;
    logic        net_write, net_read, net_ready, net_down, busy, err;
    logic [5:0]  net_address;

    int checks = 0;
    int errors = 0;

    // logs filled by the negedge monitor
    logic [5:0]  wlog_a [0:255];
    logic [31:0] wlog_d [0:255];
    logic [5:0]  rlog   [0:15];
    logic [31:0] mlog_d [0:15];
    logic        mlog_l [0:15];
    int wr_n = 0, rd_n = 0, m_n = 0, mv_n = 0;
    int stab_viol = 0, idle_viol = 0, hs_viol = 0;
    logic        hold_pending = 1'b0;
    logic [31:0] held = '0;

    always #5 clk = ~clk;

    ff_loader #(.TIMEOUT(16)) dut (
        .clk_i(clk), .reset_i(reset), .cfg_start_i(cfg_start), .cfg_load_w_i(cfg_load_w),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
        .net_write_o(net_write), .net_read_o(net_read), .net_address_o(net_address),
        .net_in_d_o(net_in_d), .net_out_d_i(net_out_d), .net_ready_i(net_ready),
        .net_down_i(net_down), .busy_o(busy), .err_o(err)
    );

    // network read port model: data only on the cycle after the strobe
    always @(posedge clk)
        net_out_d <= net_read ? {16'hBEEF, 10'd0, net_address} : 32'hDEADDEAD;

    always @(negedge clk) begin
        if (net_write && wr_n < 256) begin
            wlog_a[wr_n] = net_address;
            wlog_d[wr_n] = net_in_d;
            wr_n++;
        end
        if (net_read && rd_n < 16) begin
            rlog[rd_n] = net_address;
            rd_n++;
        end
        if (m_valid) mv_n++;
        if (m_valid && m_ready && m_n < 16) begin
            mlog_d[m_n] = m_data;
            mlog_l[m_n] = m_last;
            m_n++;
        end
        if (hold_pending && !(m_valid === 1'b1 && m_data === held)) stab_viol++;
        hold_pending = m_valid && !m_ready;
        held = m_data;
        if (!net_write && !net_read && (net_address !== 6'd0 || net_in_d !== 32'd0)) idle_viol++;
        if (net_write && net_read) idle_viol++;
        if (net_write !== (s_valid & s_ready)) hs_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic lw);
        cfg_start  = 1'b1;
        cfg_load_w = lw;
        tick();
        cfg_start  = 1'b0;
        cfg_load_w = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        int g;
        g = 0;
        s_valid = 1'b1;
        s_data  = w;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            @(posedge clk);
            #1;
            g++;
            if (g > 40) break;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = '0;
        check($sformatf("push accepted w=%0d", w), g <= 40, 1);
    endtask

    task automatic wait_m(input int target, input string tag);
        int g;
        g = 0;
        while (m_n < target && g < 80) begin
            tick();
            g++;
        end
        check(tag, m_n >= target, 1);
    endtask

    // expected write address: weights at 0..39, inputs at 41..48
    task automatic check_writes(input string tag, input int base, input int n,
                                input int first, input logic lw);
        for (int i = 0; i < n; i++) begin
            int ea;
            ea = (lw && i < 40) ? i : (lw ? 41 + i - 40 : 41 + i);
            check($sformatf("%s addr[%0d]", tag, i), wlog_a[base+i], ea);
            check($sformatf("%s data[%0d]", tag, i), wlog_d[base+i], first + i);
        end
    endtask

    task automatic check_results(input string tag, input int br, input int bm);
        check({tag, " rd0 addr"}, rlog[br],   6'd50);
        check({tag, " rd1 addr"}, rlog[br+1], 6'd51);
        check({tag, " m0 data"},  mlog_d[bm],   32'hBEEF0032);
        check({tag, " m1 data"},  mlog_d[bm+1], 32'hBEEF0033);
        check({tag, " m0 last"},  mlog_l[bm],   0);
        check({tag, " m1 last"},  mlog_l[bm+1], 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bw, br, bm, w0, r0, m0, g;
        reset = 1'b1; cfg_start = 1'b0; cfg_load_w = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1; net_ready = 1'b1; net_down = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst flags", {s_ready, m_valid, m_last, net_write, net_read, busy, err}, 0);
        check("rst m_data", m_data, 0);
        check("rst net_address", net_address, 0);
        check("rst net_in_d", net_in_d, 0);

        // full frame with weights
        bw = wr_n; br = rd_n; bm = m_n;
        start(1'b1);
        check("t1 busy", busy, 1);
        for (int i = 0; i < 48; i++) push(i);
        net_down = 1'b1;
        wait_m(bm + 2, "t1 results");
        net_down = 1'b0;
        check("t1 busy after", busy, 0);
        check("t1 write count", wr_n - bw, 48);
        check("t1 read count", rd_n - br, 2);
        check_writes("t1", bw, 48, 0, 1'b1);
        check_results("t1", br, bm);

        // inputs only, with an ignored cfg_start mid-load
        bw = wr_n; br = rd_n; bm = m_n;
        start(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin cfg_start = 1'b1; cfg_load_w = 1'b1; end
            push(100 + i);
            cfg_start = 1'b0; cfg_load_w = 1'b0;
        end
        net_down = 1'b1;
        wait_m(bm + 2, "t2 results");
        net_down = 1'b0;
        check("t2 write count", wr_n - bw, 8);
        check_writes("t2", bw, 8, 100, 1'b0);
        check_results("t2", br, bm);

        // backpressure
        bw = wr_n; br = rd_n; bm = m_n;
        start(1'b1);
        for (int i = 0; i < 48; i++) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            if (i == 20) begin
                s_valid = 1'b1; s_data = 200 + i; net_ready = 1'b0; w0 = wr_n;
                repeat (5) begin
                    tick();
                    check("t3 stall s_ready", s_ready, 0);
                end
                check("t3 no write in stall", wr_n - w0, 0);
                net_ready = 1'b1;
            end
            push(200 + i);
        end
        m_ready = 1'b0;
        net_down = 1'b1;
        g = 0;
        while (!m_valid && g < 40) begin tick(); g++; end
        check("t3 m_valid seen", m_valid, 1);
        repeat (3) tick();
        check("t3 held valid", m_valid, 1);
        check("t3 held data", m_data, 32'hBEEF0032);
        check("t3 held last", m_last, 0);
        m_ready = 1'b1;
        wait_m(bm + 2, "t3 results");
        check("t3 write count", wr_n - bw, 48);
        check_writes("t3", bw, 48, 200, 1'b1);
        check_results("t3", br, bm);

        // stale completion: net_down still high from last frame through GUARD
        bw = wr_n; br = rd_n; bm = m_n;
        start(1'b0);
        for (int i = 0; i < 8; i++) push(300 + i);
        tick();
        net_down = 1'b0;
        r0 = rd_n;
        repeat (5) tick();
        check("t4 no early read", rd_n - r0, 0);
        check("t4 still busy", busy, 1);
        net_down = 1'b1;
        wait_m(bm + 2, "t4 results");
        net_down = 1'b0;
        check_writes("t4", bw, 8, 300, 1'b0);
        check_results("t4", br, bm);

        // timeout: WAIT_DONE entered on the edge after GUARD
        start(1'b0);
        for (int i = 0; i < 8; i++) push(400 + i);
        m0 = mv_n; r0 = rd_n;
        tick();
        repeat (15) tick();
        check("t5 busy before timeout", busy, 1);
        check("t5 err before timeout", err, 0);
        tick();
        check("t5 busy at timeout", busy, 0);
        check("t5 err at timeout", err, 1);
        check("t5 no m_valid", mv_n - m0, 0);
        check("t5 no read", rd_n - r0, 0);
        start(1'b0);
        check("t5 err cleared", err, 0);
        check("t5 busy restart", busy, 1);

        // reset at weight word 20
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bw = wr_n;
        start(1'b1);
        for (int i = 0; i < 20; i++) push(i);
        s_valid = 1'b1; s_data = 20; reset = 1'b1; w0 = wr_n;
        tick();
        reset = 1'b0;
        #1;
        check("t6 flags after reset", {s_ready, m_valid, m_last, net_write, net_read, busy, err}, 0);
        check("t6 m_data after reset", m_data, 0);
        check("t6 net_address after reset", net_address, 0);
        check("t6 net_in_d after reset", net_in_d, 0);
        check("t6 no write in reset", wr_n - w0, 0);
        check_writes("t6a", bw, 20, 0, 1'b1);
        s_valid = 1'b0;
        tick();
        bw = wr_n;
        start(1'b1);
        for (int i = 0; i < 3; i++) push(32'h70 + i);
        check_writes("t6b", bw, 3, 32'h70, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        check("stable m_data under backpressure", stab_viol, 0);
        check("idle strobe values zero", idle_viol, 0);
        check("write equals handshake", hs_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
